// File: rtl/interrupt_pkg.sv
// interrupt_pkg: shared definitions for the interrupt-instruction interface.
//   JUMP_INSTR / FRAME_INSTR : the only recognised event words (also used by
//                              the instruction builders on the controller side)
//   state_t                  : dispatcher FSM states
//   ev_kind_t                : classification of an incoming event word
//   classify()               : maps a 32-bit word to its event kind
package interrupt_pkg;

  localparam logic [31:0] JUMP_INSTR  = 32'h0040_006F;
  localparam logic [31:0] FRAME_INSTR = 32'h0080_006F;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OFFER   = 2'd1,
    SERVICE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    EV_NONE  = 2'd0,
    EV_JUMP  = 2'd1,
    EV_FRAME = 2'd2,
    EV_BAD   = 2'd3
  } ev_kind_t;

  function automatic ev_kind_t classify(input logic [31:0] word);
    ev_kind_t kind;
    case (word)
      32'h0000_0000: kind = EV_NONE;
      JUMP_INSTR:    kind = EV_JUMP;
      FRAME_INSTR:   kind = EV_FRAME;
      default:       kind = EV_BAD;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/interrupt_dispatcher_irq_fifo.sv
// irq_fifo: synchronous FIFO holding queued interrupt words plus a frame tag.
//   clk, reset  : clock, asynchronous active-low reset (empties the FIFO)
//   push/data   : write one entry (caller guarantees room or a same-cycle pop)
//   pop         : retire the head entry (caller guarantees non-empty)
//   head        : current head entry (first-word-fall-through)
//   full, empty : occupancy flags
//   count       : number of stored entries, 0..DEPTH
module irq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {(AW+1){1'b0}};
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == {(AW+1){1'b0}});

endmodule

// File: rtl/interrupt_dispatcher.sv
// interrupt_dispatcher: receives one-cycle interrupt words, classifies and
// queues them, and offers them one at a time to the fetch stage.
//   proc_clk, reset        : clock, asynchronous active-low reset
//   interrupt_instruction  : event word, 0 = no event
//   fetch_ready            : fetch stage takes the offered word
//   isr_done               : service-routine return pulse
//   clear_flags            : clears overflow, bad_instr, dropped_frames
//   inject_valid/_instruction : offered word (held stable until accepted)
//   in_service             : accepted interrupt awaiting isr_done
//   pending                : FIFO occupancy
//   dropped_frames         : saturating count of coalesced/dropped frames
//   overflow, bad_instr    : sticky error flags
module interrupt_dispatcher
  import interrupt_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     proc_clk,
  input  logic                     reset,
  input  logic [31:0]              interrupt_instruction,
  input  logic                     fetch_ready,
  input  logic                     isr_done,
  input  logic                     clear_flags,
  output logic                     inject_valid,
  output logic [31:0]              inject_instruction,
  output logic                     in_service,
  output logic [$clog2(DEPTH):0]   pending,
  output logic [CNT_W-1:0]         dropped_frames,
  output logic                     overflow,
  output logic                     bad_instr
);

  localparam int PW = $clog2(DEPTH) + 1;

  state_t      state;
  state_t      next_state;
  ev_kind_t    ev;
  logic        pop;
  logic        push;
  logic        full;
  logic        empty;
  logic [32:0] head;
  logic [32:0] push_data;
  logic        room;
  logic        jump_push;
  logic        frame_push;
  logic        frame_drop;
  logic        overflow_set;
  logic [PW-1:0] frame_count;

  irq_fifo #(.DEPTH(DEPTH), .WIDTH(33)) u_fifo (
    .clk       (proc_clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (pending)
  );

  // Classification and coalescing; a full FIFO still accepts when a pop frees a slot.
  always_comb begin
    ev           = classify(interrupt_instruction);
    room         = !full || pop;
    jump_push    = (ev == EV_JUMP) && room;
    overflow_set = (ev == EV_JUMP) && !room;
    frame_push   = (ev == EV_FRAME) && room && (frame_count == {PW{1'b0}});
    frame_drop   = (ev == EV_FRAME) && !frame_push;
    push         = jump_push || frame_push;
    push_data    = {frame_push, interrupt_instruction};
  end

  // FSM next-state and pop decision.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = OFFER;
        end else begin
          next_state = IDLE;
        end
      end
      OFFER: begin
        if (fetch_ready) next_state = SERVICE;
        else             next_state = OFFER;
      end
      SERVICE: begin
        if (isr_done) next_state = IDLE;
        else          next_state = SERVICE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register plus registered handshake outputs decoded from next state.
  always_ff @(posedge proc_clk or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      inject_valid       <= 1'b0;
      in_service         <= 1'b0;
      inject_instruction <= 32'h0000_0000;
    end else begin
      state        <= next_state;
      inject_valid <= (next_state == OFFER);
      in_service   <= (next_state == SERVICE);
      if (pop) inject_instruction <= head[31:0];
    end
  end

  // Number of frame entries queued; the head tag marks a frame pop.
  always_ff @(posedge proc_clk or negedge reset) begin
    if (!reset) begin
      frame_count <= {PW{1'b0}};
    end else begin
      case ({frame_push, pop && head[32]})
        2'b10:   frame_count <= frame_count + PW'(1);
        2'b01:   frame_count <= frame_count - PW'(1);
        default: frame_count <= frame_count;
      endcase
    end
  end

  // Sticky flags and dropped-frame counter; a same-cycle event beats clear_flags.
  always_ff @(posedge proc_clk or negedge reset) begin
    if (!reset) begin
      overflow       <= 1'b0;
      bad_instr      <= 1'b0;
      dropped_frames <= {CNT_W{1'b0}};
    end else begin
      if (overflow_set)     overflow <= 1'b1;
      else if (clear_flags) overflow <= 1'b0;

      if (ev == EV_BAD)     bad_instr <= 1'b1;
      else if (clear_flags) bad_instr <= 1'b0;

      if (frame_drop) begin
        if (dropped_frames != {CNT_W{1'b1}}) dropped_frames <= dropped_frames + CNT_W'(1);
      end else if (clear_flags) begin
        dropped_frames <= {CNT_W{1'b0}};
      end
    end
  end

endmodule

// File: doc/interrupt_dispatcher.md
# interrupt_dispatcher

CPU-side receiving end of the interrupt-instruction interface driven by the input controller. Captures single-cycle interrupt instruction words (jump key, frame ready), classifies and buffers them in a small FIFO, and offers them one at a time to the processor fetch stage with a valid/ready handshake. The processor signals return from the service routine. Interrupts are non-nesting, and redundant frame-ready events are coalesced.

## Interface
- DEPTH, 4: FIFO entries, power of two, 2..16
- CNT_W, 8: width of dropped-frame counter
- proc_clk  in  1  processor clock; single clock domain
- reset  in  1  asynchronous, active-low reset
- interrupt_instruction  in  32  one-cycle event word from the input controller; 0 = no event
- fetch_ready  in  1  fetch stage accepts the injected word this cycle
- isr_done  in  1  one-cycle pulse at service-routine return
- clear_flags  in  1  clears the sticky flags and dropped_frames
- inject_valid  out  1  inject_instruction is valid
- inject_instruction  out  32  interrupt word offered to fetch
- in_service  out  1  an interrupt has been accepted and isr_done has not yet arrived
- pending  out  $clog2(DEPTH)+1  FIFO occupancy
- dropped_frames  out  CNT_W  coalesced or dropped frame-ready events; saturating
- overflow  out  1  sticky: a jump event was lost because the FIFO was full
- bad_instr  out  1  sticky: an unrecognised nonzero word was received

## Operation
- Classification, on a nonzero input word:
  - Equal to JUMP_INSTR: jump event.
  - Equal to FRAME_INSTR: frame event.
  - Anything else: discarded; bad_instr set.
- Jump event:
  - FIFO not full: push.
  - FIFO full and no pop this cycle: discard, set overflow.
  - Full with a simultaneous pop: accept the push.
- Frame event:
  - If a frame entry is already queued (frame_count > 0), or the push is rejected for fullness: discard and increment dropped_frames (saturates at all-ones).
  - Otherwise push.
- frame_count: tracks the number of frame entries in the FIFO. Increments on a frame push and decrements on a frame pop; both in one cycle leaves it unchanged.
- FIFO order is strictly preserved; there is no reprioritisation.
- FSM states:
  - IDLE: inject_valid=0. If FIFO is non-empty, load the head into the output register, pop, and go to OFFER.
  - OFFER: inject_valid=1, with the word held stable until fetch_ready. On fetch_ready, go to SERVICE.
  - SERVICE: inject_valid=0, in_service=1. On isr_done, go to IDLE.
- isr_done in IDLE or OFFER is ignored.
- clear_flags zeroes overflow, bad_instr and dropped_frames. A same-cycle set wins over clear.
- Reset (asynchronous, active-low):
  - FSM returns to IDLE.
  - FIFO emptied; frame_count = 0.
  - All outputs 0: inject_instruction = 0, pending = 0, counters and flags cleared.
- Reset mid-OFFER or mid-SERVICE abandons the interrupt; no replay.

## Timing
- Capture to FIFO: the push is registered on the edge where the input word is present, so pending rises the next cycle.
- Capture to inject_valid: 2 cycles minimum (push edge, then the IDLE load edge), with an empty FIFO and the FSM in IDLE.
- Handshake: accepted on the edge where inject_valid && fetch_ready. inject_valid is 0 the next cycle.
- After isr_done, the next queued word appears 2 cycles later (SERVICE→IDLE edge, then the load edge).
- The pop in IDLE and a push in the same cycle are both honoured. pending changes by net push − pop.
- All outputs are registered; there are no combinational input→output paths.

## Structure
- A shared package, interrupt_pkg, holds:
  - JUMP_INSTR and FRAME_INSTR constants, also consumed by the instruction builders.
  - The state enum {IDLE, OFFER, SERVICE}.
  - An event-kind enum {EV_NONE, EV_JUMP, EV_FRAME, EV_BAD}.
- Sub-module irq_fifo: synchronous FIFO of width 33 (word plus frame tag) and depth DEPTH, providing full, empty and count.
- Classification, coalescing, counters and the FSM live in the top level.

## Test plan
- Single jump word at cycle 10, fetch_ready=1 → inject_valid high at cycle 12 with JUMP_INSTR; after acceptance in_service=1. isr_done at cycle 20 → in_service=0 at cycle 21.
- Three frame words, 5 cycles apart, while in SERVICE → pending=1, dropped_frames=2. After isr_done, exactly one FRAME_INSTR is offered.
- DEPTH=4 filled with jump words during SERVICE; a 5th jump arrives → overflow=1, pending=4. clear_flags → overflow=0 the next cycle.
- fetch_ready held low for 6 cycles in OFFER → inject_valid and inject_instruction remain constant. Raising fetch_ready completes the handshake on that edge.
- Word 32'hDEADBEEF → bad_instr=1, pending unchanged, no injection.
- reset driven low mid-OFFER with 2 pending → on the next cycle all outputs are 0, pending=0, and no injection follows.
